// File: rtl/video_line_tracker.sv
// Camera input timing stage: re-times the raw fval/lval/pixel stream and derives
// the per-line address, newline pulse, mod-5 line phase and frame enable used downstream.
module video_line_tracker #(
  parameter int LINE_LEN          = 640,
  parameter int LINES_PER_FRAME   = 480,
  parameter int bit_depth_lines   = 10,
  parameter int width_of_data_pix = 8
) (
  input  logic                         clk_in,
  input  logic                         rst,
  input  logic                         fval,
  input  logic                         lval,
  input  logic [width_of_data_pix-1:0] input_pix,
  output logic [width_of_data_pix-1:0] output_pix,
  output logic                         pix_valid,
  output logic [bit_depth_lines-1:0]   lines,
  output logic                         newline,
  output logic [2:0]                   line_phase,
  output logic [bit_depth_lines-1:0]   line_cnt,
  output logic                         enable,
  output logic                         frame_start,
  output logic                         frame_end,
  output logic                         err_len,
  output logic                         err_frame
);

  // One extra counter bit so a full line (LINE_LEN may equal 2^bit_depth_lines) is representable.
  localparam int CW = bit_depth_lines + 1;
  localparam logic [CW-1:0] FULL_LINE = CW'(LINE_LEN);
  localparam logic [bit_depth_lines-1:0] EXP_LINES = bit_depth_lines'(LINES_PER_FRAME);

  localparam logic [1:0] S_SYNC       = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_WAIT_LINE  = 2'd2;
  localparam logic [1:0] S_LINE       = 2'd3;

  logic [1:0]                 state;
  logic [CW-1:0]              pix_cnt;
  logic                       overflow;
  logic                       line_good;
  logic [bit_depth_lines-1:0] cnt_inc;
  logic [bit_depth_lines-1:0] end_cnt;
  logic [2:0]                 phase_inc;

  // end_cnt is the line count as it will stand after this edge, so a line closing
  // together with the frame is already included in the frame-length check.
  always_comb begin
    line_good = (pix_cnt == FULL_LINE) && !overflow;
    cnt_inc   = (&line_cnt) ? line_cnt : line_cnt + bit_depth_lines'(1);
    phase_inc = (line_phase == 3'd4) ? 3'd0 : line_phase + 3'd1;
    end_cnt   = (!lval && line_good) ? cnt_inc : line_cnt;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state       <= S_SYNC;
      pix_cnt     <= '0;
      overflow    <= 1'b0;
      output_pix  <= '0;
      pix_valid   <= 1'b0;
      lines       <= '0;
      newline     <= 1'b0;
      line_phase  <= 3'd0;
      line_cnt    <= '0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      err_len     <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      newline     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      case (state)
        S_SYNC: begin
          if (!fval) state <= S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (fval) begin
            frame_start <= 1'b1;
            line_cnt    <= '0;
            line_phase  <= 3'd0;
            enable      <= 1'b1;
            state       <= S_WAIT_LINE;
          end
        end
        S_WAIT_LINE: begin
          if (!fval) begin
            frame_end <= 1'b1;
            enable    <= 1'b0;
            if (line_cnt != EXP_LINES) err_frame <= 1'b1;
            state     <= S_WAIT_FRAME;
          end else if (lval) begin
            output_pix <= input_pix;
            lines      <= '0;
            pix_valid  <= 1'b1;
            pix_cnt    <= CW'(1);
            overflow   <= 1'b0;
            state      <= S_LINE;
          end
        end
        S_LINE: begin
          if (fval && lval) begin
            if (pix_cnt < FULL_LINE) begin
              output_pix <= input_pix;
              lines      <= pix_cnt[bit_depth_lines-1:0];
              pix_valid  <= 1'b1;
              pix_cnt    <= pix_cnt + CW'(1);
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            // Line closed (lval low) or aborted (fval dropped mid-line).
            if (!lval && line_good) begin
              newline    <= 1'b1;
              line_cnt   <= cnt_inc;
              line_phase <= phase_inc;
            end else begin
              err_len <= 1'b1;
            end
            if (!fval) begin
              frame_end <= 1'b1;
              enable    <= 1'b0;
              if (end_cnt != EXP_LINES) err_frame <= 1'b1;
              state     <= S_WAIT_FRAME;
            end else begin
              state <= S_WAIT_LINE;
            end
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_video_line_tracker.sv
// Directed, table-driven bench for video_line_tracker with LINE_LEN=8, LINES_PER_FRAME=4
// and a 3-bit line address, so the full-line count needs the counter's extra bit.
module tb_video_line_tracker;

  typedef struct packed {
    logic       pix_valid;
    logic [2:0] lines;
    logic [7:0] output_pix;
    logic       newline;
    logic [2:0] line_phase;
    logic [2:0] line_cnt;
    logic       enable;
    logic       frame_start;
    logic       frame_end;
    logic       err_len;
    logic       err_frame;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       fval;
    logic       lval;
    logic [7:0] pix;
    out_t       exp;
  } vec_t;

  logic       clk_in;
  logic       rst;
  logic       fval;
  logic       lval;
  logic [7:0] input_pix;
  logic [7:0] output_pix;
  logic       pix_valid;
  logic [2:0] lines;
  logic       newline;
  logic [2:0] line_phase;
  logic [2:0] line_cnt;
  logic       enable;
  logic       frame_start;
  logic       frame_end;
  logic       err_len;
  logic       err_frame;

  vec_t table_q[$];
  int   total;
  int   bad;

  // Expected slow-moving state, updated by hand as each scenario is laid out.
  logic [2:0] e_cnt;
  logic [2:0] e_phase;
  logic       e_en;
  logic       e_el;
  logic       e_ef;

  video_line_tracker #(
    .LINE_LEN         (8),
    .LINES_PER_FRAME  (4),
    .bit_depth_lines  (3),
    .width_of_data_pix(8)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .fval       (fval),
    .lval       (lval),
    .input_pix  (input_pix),
    .output_pix (output_pix),
    .pix_valid  (pix_valid),
    .lines      (lines),
    .newline    (newline),
    .line_phase (line_phase),
    .line_cnt   (line_cnt),
    .enable     (enable),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .err_len    (err_len),
    .err_frame  (err_frame)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic out_t mk(input logic pv, input logic [2:0] ln, input logic [7:0] px,
                              input logic nl, input logic fs, input logic fe);
    out_t o;
    o.pix_valid   = pv;
    o.lines       = ln;
    o.output_pix  = px;
    o.newline     = nl;
    o.line_phase  = e_phase;
    o.line_cnt    = e_cnt;
    o.enable      = e_en;
    o.frame_start = fs;
    o.frame_end   = fe;
    o.err_len     = e_el;
    o.err_frame   = e_ef;
    return o;
  endfunction

  task automatic push(input logic r, input logic f, input logic l, input logic [7:0] p, input out_t e);
    vec_t v;
    v.rst  = r;
    v.fval = f;
    v.lval = l;
    v.pix  = p;
    v.exp  = e;
    table_q.push_back(v);
  endtask

  task automatic addRst(input logic f, input logic l);
    e_cnt = 3'd0; e_phase = 3'd0; e_en = 1'b0; e_el = 1'b0; e_ef = 1'b0;
    push(1'b1, f, l, 8'h00, out_t'(0));
  endtask

  task automatic addIdle();
    push(1'b0, 1'b0, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic addFrameStart();
    e_cnt = 3'd0; e_phase = 3'd0; e_en = 1'b1;
    push(1'b0, 1'b1, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0));
  endtask

  task automatic addFrameEnd();
    e_en = 1'b0;
    if (e_cnt != 3'd4) e_ef = 1'b1;
    push(1'b0, 1'b0, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1));
  endtask

  // Pixels beyond the eighth are dropped, so only the first eight are expected valid.
  task automatic addPixels(input int n, input int base);
    for (int k = 0; k < n; k++)
      push(1'b0, 1'b1, 1'b1, 8'(base + k), mk(k < 8, 3'(k), 8'(base + k), 1'b0, 1'b0, 1'b0));
  endtask

  task automatic addGoodLine(input int base, input int gap);
    addPixels(8, base);
    e_cnt   = (e_cnt == 3'd7) ? 3'd7 : e_cnt + 3'd1;
    e_phase = (e_phase == 3'd4) ? 3'd0 : e_phase + 3'd1;
    for (int g = 0; g < gap; g++)
      push(1'b0, 1'b1, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, g == 0, 1'b0, 1'b0));
  endtask

  task automatic addBadLine(input int n, input int base);
    addPixels(n, base);
    e_el = 1'b1;
    push(1'b0, 1'b1, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic l, input logic [7:0] p);
    @(negedge clk_in);
    rst       = r;
    fval      = f;
    lval      = l;
    input_pix = p;
    @(posedge clk_in);
    #1;
  endtask

  // Address and pixel are only meaningful while pix_valid is expected high.
  task automatic checkOutput(input out_t e, input string name);
    out_t a;
    a.pix_valid   = pix_valid;
    a.lines       = lines;
    a.output_pix  = output_pix;
    a.newline     = newline;
    a.line_phase  = line_phase;
    a.line_cnt    = line_cnt;
    a.enable      = enable;
    a.frame_start = frame_start;
    a.frame_end   = frame_end;
    a.err_len     = err_len;
    a.err_frame   = err_frame;
    if (!e.pix_valid) begin
      a.lines      = e.lines;
      a.output_pix = e.output_pix;
    end
    total++;
    if (a !== e) begin
      bad++;
      $display("[TB] FAIL %s: got pv=%b ln=%0d px=%h nl=%b ph=%0d cnt=%0d en=%b fs=%b fe=%b el=%b ef=%b, want pv=%b ln=%0d px=%h nl=%b ph=%0d cnt=%0d en=%b fs=%b fe=%b el=%b ef=%b",
               name, a.pix_valid, a.lines, a.output_pix, a.newline, a.line_phase, a.line_cnt,
               a.enable, a.frame_start, a.frame_end, a.err_len, a.err_frame,
               e.pix_valid, e.lines, e.output_pix, e.newline, e.line_phase, e.line_cnt,
               e.enable, e.frame_start, e.frame_end, e.err_len, e.err_frame);
    end
  endtask

  task automatic runVec(input logic r, input logic f, input logic l, input logic [7:0] p,
                        input out_t e, input string name);
    applyStimulus(r, f, l, p);
    checkOutput(e, name);
  endtask

  task automatic runTable(input string tag);
    foreach (table_q[i]) begin
      applyStimulus(table_q[i].rst, table_q[i].fval, table_q[i].lval, table_q[i].pix);
      checkOutput(table_q[i].exp, $sformatf("%s_vec%0d", tag, i));
    end
    table_q.delete();
  endtask

  initial begin
    rst = 1'b1; fval = 1'b0; lval = 1'b0; input_pix = 8'h00;
    total = 0; bad = 0;
    e_cnt = 3'd0; e_phase = 3'd0; e_en = 1'b0; e_el = 1'b0; e_ef = 1'b0;

    // Reset, then one clean 4x8 frame with 2-cycle line gaps.
    addRst(1'b0, 1'b0);
    addIdle();
    addFrameStart();
    for (int ln = 0; ln < 4; ln++) addGoodLine(ln * 8, 2);
    addFrameEnd();
    addIdle();
    // Two back-to-back frames with minimum 1-cycle line gaps.
    for (int fr = 1; fr < 3; fr++) begin
      addFrameStart();
      for (int ln = 0; ln < 4; ln++) addGoodLine(fr * 37 + ln * 8, 1);
      addFrameEnd();
    end
    // Nine-line frame: phase wraps 4->0, line_cnt saturates at 7, frame length error.
    addFrameStart();
    for (int ln = 0; ln < 9; ln++) addGoodLine(100 + ln * 8, 1);
    addFrameEnd();
    runTable("main");

    // Clean frame whose last line ends on the same edge as the frame.
    addRst(1'b0, 1'b0);
    addIdle();
    addFrameStart();
    for (int ln = 0; ln < 3; ln++) addGoodLine(150 + ln * 8, 2);
    addPixels(8, 180);
    runTable("pre_fall");
    e_cnt = 3'd4; e_phase = 3'd4; e_en = 1'b0;
    runVec(1'b0, 1'b0, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1), "same_edge_fall");
    runVec(1'b0, 1'b0, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0), "after_fall");

    // Short line then long line: no newline, err_len, then err_frame at frame end.
    addFrameStart();
    addBadLine(7, 200);
    push(1'b0, 1'b1, 1'b0, 8'h00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0));
    addBadLine(10, 220);
    addFrameEnd();
    runTable("badlen");

    // Reset during pixel 3 of line 2 with fval held high through reset release.
    addRst(1'b0, 1'b0);
    addIdle();
    addFrameStart();
    addGoodLine(50, 1);
    addPixels(2, 60);
    runTable("pre_rst");
    e_cnt = 3'd0; e_phase = 3'd0; e_en = 1'b0; e_el = 1'b0; e_ef = 1'b0;
    runVec(1'b1, 1'b1, 1'b1, 8'd62, out_t'(0), "rst_midline");
    runVec(1'b0, 1'b1, 1'b1, 8'd63, out_t'(0), "sync_ignores_fval");
    runVec(1'b0, 1'b1, 1'b1, 8'd64, out_t'(0), "sync_ignores_pixels");
    runVec(1'b0, 1'b1, 1'b0, 8'd00, out_t'(0), "no_newline_aborted");
    runVec(1'b0, 1'b0, 1'b0, 8'd00, out_t'(0), "sync_sees_fval_low");
    e_en = 1'b1;
    runVec(1'b0, 1'b1, 1'b0, 8'd00, mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0), "frame_start_after_fall");
    runVec(1'b0, 1'b1, 1'b1, 8'h5a, mk(1'b1, 3'd0, 8'h5a, 1'b0, 1'b0, 1'b0), "first_pix_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
